// File: rtl/piso_reg_pkg.sv
// Shared definitions for the piso_reg serializer: FSM state encoding.
package piso_reg_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage : piso_reg_pkg

// File: rtl/piso_hold_buf.sv
// One-word holding buffer that lets the next word wait while the current one shifts out.
module piso_hold_buf #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             full_o
);

  logic [width-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  // NOTE: the stored word is cleared on reset as well, so a stale word can never resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule : piso_hold_buf

// File: rtl/piso_reg.sv
// Parallel-in serial-out serializer with valid/last strobes and a one-word hold buffer.
module piso_reg
  import piso_reg_pkg::*;
#(
  parameter int width     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int            CW      = $clog2(width);
  localparam logic [CW-1:0] CNT_MAX = CW'(width - 1);

  state_e           state_q, state_d;
  logic [width-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             hold_wr, hold_rd, hold_full, hold_full_next;
  logic [width-1:0] hold_data;

  assign ready  = ~hold_full;
  assign accept = load & ready;

  piso_hold_buf #(.width(width)) u_hold_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (hold_wr),
    .rd_i   (hold_rd),
    .data_i (data_in),
    .data_o (hold_data),
    .full_o (hold_full)
  );

  assign sr_shift = MSB_FIRST ? {sr_q[width-2:0], 1'b0} : {1'b0, sr_q[width-1:1]};

  // NOTE: every signal gets its default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d    = data_in;
          cnt_d   = CNT_MAX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          sr_d    = sr_shift;
          cnt_d   = cnt_q - CW'(1);
          hold_wr = accept;
        end else if (hold_full) begin
          sr_d    = hold_data;
          cnt_d   = CNT_MAX;
          hold_rd = 1'b1;
        end else if (accept) begin
          sr_d  = data_in;
          cnt_d = CNT_MAX;
        end else begin
          // Clearing the shift reg keeps serial_out at 0 while idle.
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hold_full_next = hold_wr | (hold_full & ~hold_rd);
  assign last_d         = (state_d == S_SHIFT) && (cnt_d == '0);
  assign busy_d         = (state_d == S_SHIFT) | hold_full_next;

  // NOTE: non-blocking assignments so all state updates see the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign serial_valid = (state_q == S_SHIFT);
  assign serial_out   = MSB_FIRST ? sr_q[width-1] : sr_q[0];
  assign last         = last_q;
  assign busy         = busy_q;

endmodule : piso_reg

// File: tb/tb_piso_reg.sv
// Directed self-checking bench for piso_reg (MSB-first and LSB-first instances, width 8).
module tb_piso_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_m, load_l;
  logic [7:0] din_m, din_l;
  logic       ready_m, out_m, valid_m, last_m, busy_m;
  logic       ready_l, out_l, valid_l, last_l, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_reg #(.width(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load_m), .data_in(din_m),
    .ready(ready_m), .serial_out(out_m), .serial_valid(valid_m),
    .last(last_m), .busy(busy_m)
  );

  piso_reg #(.width(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load(load_l), .data_in(din_l),
    .ready(ready_l), .serial_out(out_l), .serial_valid(valid_l),
    .last(last_l), .busy(busy_l)
  );

  // Vectors compared below are {ready, busy, last, serial_valid, serial_out}.
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_msb: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
    n_cmp++;
    if ({ready_l, busy_l, last_l, valid_l, out_l} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_lsb: got %b required %b", {ready_l, busy_l, last_l, valid_l, out_l}, 5'b10000);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_msb();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'hA5;
    load_m = 1'b1; din_m = w;
    @(negedge clk);
    load_m = 1'b0; din_m = '0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 1'b1, (i == 7), 1'b1, w[7-i]};
      n_cmp++;
      if ({ready_m, busy_m, last_m, valid_m, out_m} !== exp) begin
        n_err++;
        $display("FAIL single_msb bit%0d: got %b required %b", i, {ready_m, busy_m, last_m, valid_m, out_m}, exp);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL single_msb idle: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic [4:0]  exp;
    s = {8'hA5, 8'h3C};
    load_m = 1'b1; din_m = 8'hA5;
    @(negedge clk);
    load_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = {!(i >= 1 && i <= 7), 1'b1, (i == 7 || i == 15), 1'b1, s[15-i]};
      n_cmp++;
      if ({ready_m, busy_m, last_m, valid_m, out_m} !== exp) begin
        n_err++;
        $display("FAIL back_to_back bit%0d: got %b required %b", i, {ready_m, busy_m, last_m, valid_m, out_m}, exp);
      end
      if (i == 0) begin load_m = 1'b1; din_m = 8'h3C; end
      else        begin load_m = 1'b0; din_m = '0;    end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL back_to_back idle: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
  endtask

  task automatic test_last_bit_load();
    logic [15:0] s;
    logic [4:0]  exp;
    s = {8'hA5, 8'hF0};
    load_m = 1'b1; din_m = 8'hA5;
    @(negedge clk);
    load_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      // ready must stay high throughout: the hold buffer is never written.
      exp = {1'b1, 1'b1, (i == 7 || i == 15), 1'b1, s[15-i]};
      n_cmp++;
      if ({ready_m, busy_m, last_m, valid_m, out_m} !== exp) begin
        n_err++;
        $display("FAIL last_bit_load bit%0d: got %b required %b", i, {ready_m, busy_m, last_m, valid_m, out_m}, exp);
      end
      if (i == 7) begin load_m = 1'b1; din_m = 8'hF0; end
      else        begin load_m = 1'b0; din_m = '0;    end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL last_bit_load idle: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'h01;
    load_l = 1'b1; din_l = w;
    @(negedge clk);
    load_l = 1'b0; din_l = '0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 1'b1, (i == 7), 1'b1, w[i]};
      n_cmp++;
      if ({ready_l, busy_l, last_l, valid_l, out_l} !== exp) begin
        n_err++;
        $display("FAIL lsb_first bit%0d: got %b required %b", i, {ready_l, busy_l, last_l, valid_l, out_l}, exp);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_l, busy_l, last_l, valid_l, out_l} !== 5'b10000) begin
      n_err++;
      $display("FAIL lsb_first idle: got %b required %b", {ready_l, busy_l, last_l, valid_l, out_l}, 5'b10000);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [4:0] exp;
    load_m = 1'b1; din_m = 8'hFF;
    @(negedge clk);
    load_m = 1'b0; din_m = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({valid_m, out_m} !== 2'b11) begin
        n_err++;
        $display("FAIL reset_mid pre bit%0d: got %b required %b", i, {valid_m, out_m}, 2'b11);
      end
      if (i < 2) @(negedge clk);
    end
    // Assert reset between clock edges: outputs must clear without a clk edge.
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid async: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid released: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
    w = 8'h81;
    load_m = 1'b1; din_m = w;
    @(negedge clk);
    load_m = 1'b0; din_m = '0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, 1'b1, (i == 7), 1'b1, w[7-i]};
      n_cmp++;
      if ({ready_m, busy_m, last_m, valid_m, out_m} !== exp) begin
        n_err++;
        $display("FAIL reset_mid after bit%0d: got %b required %b", i, {ready_m, busy_m, last_m, valid_m, out_m}, exp);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid idle: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
  endtask

  task automatic test_load_not_ready();
    logic [15:0] s;
    logic [4:0]  exp;
    s = {8'hA5, 8'h3C};
    load_m = 1'b1; din_m = 8'hA5;
    @(negedge clk);
    load_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = {!(i >= 1 && i <= 7), 1'b1, (i == 7 || i == 15), 1'b1, s[15-i]};
      n_cmp++;
      if ({ready_m, busy_m, last_m, valid_m, out_m} !== exp) begin
        n_err++;
        $display("FAIL load_not_ready bit%0d: got %b required %b", i, {ready_m, busy_m, last_m, valid_m, out_m}, exp);
      end
      if (i == 0)                begin load_m = 1'b1; din_m = 8'h3C; end
      else if (i >= 1 && i <= 7) begin load_m = 1'b1; din_m = 8'h55; end
      else                       begin load_m = 1'b0; din_m = '0;    end
      @(negedge clk);
    end
    n_cmp++;
    if ({ready_m, busy_m, last_m, valid_m, out_m} !== 5'b10000) begin
      n_err++;
      $display("FAIL load_not_ready idle: got %b required %b", {ready_m, busy_m, last_m, valid_m, out_m}, 5'b10000);
    end
  endtask

  initial begin
    reset  = 1'b1;
    load_m = 1'b0; din_m = '0;
    load_l = 1'b0; din_l = '0;
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_last_bit_load();
    test_lsb_first();
    test_reset_mid_word();
    test_load_not_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso_reg
